pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Parametrised pipeline control unit: the successor to the fixed six-stage stall controller. It merges per-stage stall requests into a hold mask for a pipeline of `STAGES` stages, and sequences multi-cycle flushes with a redirect PC. It also runs a stall watchdog and a wrapping stall-cycle counter. It sits beside the pipeline registers; every `stall` bit drives one stage's hold enable.

## Interface
- `STAGES`, 6: number of pipeline stages; stage 0 is PC, stage `STAGES-1` is writeback.
- `ADDR_W`, 32: width of the redirect PC.
- `FLUSH_LEN`, 1: cycles `flush` stays high per accepted flush (1..15).
- `TIMEOUT`, 1024: consecutive stalled cycles that trip the watchdog (1..2^`CNT_W`-1).
- `CNT_W`, 16: width of the stall counters.
- `clk`  in  1: clock; single clock domain.
- `rst`  in  1: reset, asynchronous, active-high.
- `stall_req`  in  `STAGES`: bit k = stage k requests a hold.
- `flush_req`  in  1: single-cycle flush request (exception/redirect).
- `flush_pc`  in  `ADDR_W`: redirect target, valid with `flush_req`.
- `wd_clear`  in  1: clears `stall_timeout`.
- `stall`  out  `STAGES`: hold mask; bit k = stage k holds.
- `flush`  out  1: registered flush to all pipeline registers.
- `new_pc`  out  `ADDR_W`: registered redirect target, valid while `flush`=1.
- `stall_timeout`  out  1: sticky watchdog flag.
- `stall_cycles`  out  `CNT_W`: wrapping count of cycles with `stall`≠0.

## Operation
- **Stall mask (combinational):**
  - Let h be the highest set index of `stall_req`. Then `stall[h:0]` are all 1 and all higher bits are 0.
  - With no request, `stall`=0.
  - The stage above h sees a held upstream and inserts a bubble. That is the consumer's job, not this block's.
- **Flush FSM, states RUN and FLUSH:**
  - RUN with `flush_req`=1: go to FLUSH next cycle.
    - Latch `flush_pc` into `new_pc`.
    - Load `flush_cnt`=`FLUSH_LEN`-1.
  - FLUSH: `flush`=1.
    - If `flush_cnt`≠0, decrement it.
    - If `flush_cnt`=0, return to RUN.
  - `flush_req` while in FLUSH: the latest request wins. Relatch `new_pc`, reload `flush_cnt`=`FLUSH_LEN`-1, stay in FLUSH.
  - While in FLUSH, `stall` is forced to 0 regardless of `stall_req`. Flush outranks stall.
  - In RUN, a `flush_req` that arrives alongside `stall_req` does not suppress that cycle's stall. Suppression starts the next cycle.
- **Watchdog:**
  - `run_cnt` increments each cycle `stall`≠0, saturating at 2^`CNT_W`-1.
  - It clears to 0 on any cycle with `stall`=0.
  - When `run_cnt` reaches `TIMEOUT`-1 while `stall`≠0, `stall_timeout` sets next edge.
  - `stall_timeout` stays set until `rst` or `wd_clear`.
  - `wd_clear` and a trip in the same cycle: the trip wins (flag stays 1).
- **Statistics:** `stall_cycles` increments on each cycle with `stall`≠0 and wraps from 2^`CNT_W`-1 to 0.
- **Reset:**
  - State goes to RUN; `flush`=0, `new_pc`=0, `flush_cnt`=0, `run_cnt`=0, `stall_cycles`=0, `stall_timeout`=0.
  - `stall` then follows `stall_req` combinationally. It is 0 while `rst`=1, since `rst` forces `stall`=0.
  - Reset mid-flush aborts the flush immediately, asynchronously.

## Timing
- `stall`: zero-cycle combinational path from `stall_req`, `rst` and FSM state.
- `flush`/`new_pc`:
  - Registered, 1-cycle latency from `flush_req`.
  - High for exactly `FLUSH_LEN` cycles per isolated request.
  - Back-to-back requests extend the window to `FLUSH_LEN` cycles after the last request.
- `stall_timeout`: rises on the edge ending the `TIMEOUT`-th consecutive stalled cycle.
- `stall_cycles`: updates on the edge ending each stalled cycle.
- No handshake: requests are level (`stall_req`) or pulse (`flush_req`) and are never back-pressured.

## Test plan
- **Stall mask** (`STAGES`=6):
  - `stall_req`=000100 → `stall`=000111.
  - `stall_req`=001010 → `stall`=001111.
  - `stall_req`=000000 → `stall`=0.
  - `rst`=1 forces `stall`=0.
- **Single flush** (`FLUSH_LEN`=3):
  - Stimulus: `flush_req` pulse with `flush_pc`=0x0000_0180.
  - Required: `flush`=1 for cycles 1–3 after the request with `new_pc`=0x180, then 0.
  - Required: `stall`=0 during those cycles even with `stall_req`=111111.
- **Back-to-back flush:**
  - Stimulus: second `flush_req` with pc 0x200 in the second FLUSH cycle.
  - Required: `new_pc`=0x200 and `flush` stays high 3 cycles past the second request.
- **Watchdog** (`TIMEOUT`=8):
  - 7 stalled cycles then a gap → no trip.
  - 8 consecutive stalled cycles → `stall_timeout`=1, which holds until `wd_clear`.
  - `wd_clear` on the trip cycle → flag stays 1.
- **Counter wrap** (`CNT_W`=4): 17 stalled cycles → `stall_cycles`=1.
- **Asynchronous reset mid-flush:** assert `rst` between clock edges during FLUSH → `flush`=0, `new_pc`=0 and `stall_cycles`=0 immediately.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: stall/flush requests in, hold mask and redirect out.
interface pipe_ctrl_if #(
  parameter int STAGES = 6,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic [STAGES-1:0] stall_req;
  logic              flush_req;
  logic [ADDR_W-1:0] flush_pc;
  logic              wd_clear;
  logic [STAGES-1:0] stall;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic              stall_timeout;
  logic [CNT_W-1:0]  stall_cycles;

  // Pipeline side: raises requests, consumes hold mask and redirect.
  modport master (
    output stall_req, flush_req, flush_pc, wd_clear,
    input  stall, flush, new_pc, stall_timeout, stall_cycles
  );

  // Controller side.
  modport slave (
    input  stall_req, flush_req, flush_pc, wd_clear,
    output stall, flush, new_pc, stall_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall hold mask, multi-cycle flush sequencer with
// redirect PC, stall watchdog and wrapping stall-cycle counter.
module pipe_ctrl #(
  parameter int STAGES    = 6,
  parameter int ADDR_W    = 32,
  parameter int FLUSH_LEN = 1,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 16
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state;
  logic [3:0]        flush_cnt;
  logic [CNT_W-1:0]  run_cnt;
  logic [STAGES-1:0] mask;
  logic              stalled;
  logic              trip;

  // Hold every stage at or below the highest requesting stage: each bit is
  // the OR of its own request and all requests downstream of it.
  always_comb begin
    logic acc;
    acc  = 1'b0;
    mask = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc     = acc | bus.stall_req[k];
      mask[k] = acc;
    end
  end

  // Flush outranks stall; reset also forces the mask low.
  assign bus.stall = (rst || state == FLUSH) ? '0 : mask;
  assign stalled   = |bus.stall;
  assign trip      = stalled && (run_cnt == CNT_W'(TIMEOUT - 1));

  // Flush sequencer; a new request always restarts the window with its PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      bus.flush <= 1'b0;
      bus.new_pc <= '0;
      flush_cnt <= '0;
    end else if (bus.flush_req) begin
      state      <= FLUSH;
      bus.flush  <= 1'b1;
      bus.new_pc <= bus.flush_pc;
      flush_cnt  <= 4'(FLUSH_LEN - 1);
    end else if (state == FLUSH) begin
      if (flush_cnt != '0) begin
        flush_cnt <= flush_cnt - 4'd1;
      end else begin
        state     <= RUN;
        bus.flush <= 1'b0;
      end
    end
  end

  // Watchdog: saturating run length of consecutive stalled cycles and a
  // sticky flag; a trip beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt           <= '0;
      bus.stall_timeout <= 1'b0;
    end else begin
      if (!stalled)             run_cnt <= '0;
      else if (run_cnt != '1)   run_cnt <= run_cnt + 1'b1;
      if (trip)                 bus.stall_timeout <= 1'b1;
      else if (bus.wd_clear)    bus.stall_timeout <= 1'b0;
    end
  end

  // Statistics: wrapping count of stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          bus.stall_cycles <= '0;
    else if (stalled) bus.stall_cycles <= bus.stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed test-plan cases followed by
// randomized traffic against a cycle-level behavioural model.
module tb_pipe_ctrl;
  localparam int STAGES    = 6;
  localparam int ADDR_W    = 32;
  localparam int FLUSH_LEN = 3;
  localparam int TIMEOUT   = 8;
  localparam int CNT_W     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.STAGES(STAGES), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) pif ();

  pipe_ctrl #(
    .STAGES(STAGES), .ADDR_W(ADDR_W), .FLUSH_LEN(FLUSH_LEN),
    .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(pif)
  );

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int          m_flush_left;
  logic [31:0] m_pc;
  int          m_consec;
  int          m_cycles;
  logic        m_to;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold mask from the highest requesting stage: stages 0..h held.
  function automatic logic [STAGES-1:0] ref_mask(input logic [STAGES-1:0] req);
    int h;
    h = -1;
    for (int k = 0; k < STAGES; k++) if (req[k]) h = k;
    if (h < 0) return '0;
    return STAGES'((64'd2 << h) - 64'd1);
  endfunction

  task automatic model_reset();
    m_flush_left = 0;
    m_pc         = '0;
    m_consec     = 0;
    m_cycles     = 0;
    m_to         = 1'b0;
  endtask

  // One clock: drive inputs after negedge, check the combinational mask,
  // advance the model over the edge, then check registered outputs.
  task automatic step(input logic [STAGES-1:0] sreq, input logic freq,
                      input logic [31:0] fpc, input logic wdc);
    logic [STAGES-1:0] es;
    @(negedge clk);
    pif.stall_req = sreq;
    pif.flush_req = freq;
    pif.flush_pc  = fpc;
    pif.wd_clear  = wdc;
    #1;
    es = (m_flush_left > 0) ? '0 : ref_mask(sreq);
    chk("stall", 64'(pif.stall), 64'(es));
    if (es != '0) begin
      m_consec++;
      m_cycles = (m_cycles + 1) % (1 << CNT_W);
    end else begin
      m_consec = 0;
    end
    if (es != '0 && m_consec == TIMEOUT) m_to = 1'b1;
    else if (wdc)                        m_to = 1'b0;
    if (freq) begin
      m_flush_left = FLUSH_LEN;
      m_pc         = fpc;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end
    @(posedge clk);
    #1;
    chk("flush", 64'(pif.flush), 64'(m_flush_left > 0));
    if (m_flush_left > 0) chk("new_pc", 64'(pif.new_pc), 64'(m_pc));
    chk("stall_timeout", 64'(pif.stall_timeout), 64'(m_to));
    chk("stall_cycles", 64'(pif.stall_cycles), 64'(m_cycles));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pif.stall_req = '1;
    #1;
    model_reset();
    chk("rst_stall", 64'(pif.stall), 64'd0);
    chk("rst_flush", 64'(pif.flush), 64'd0);
    chk("rst_new_pc", 64'(pif.new_pc), 64'd0);
    chk("rst_cycles", 64'(pif.stall_cycles), 64'd0);
    chk("rst_timeout", 64'(pif.stall_timeout), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pif.stall_req = '0;
  endtask

  initial begin
    pif.stall_req = '0;
    pif.flush_req = 1'b0;
    pif.flush_pc  = '0;
    pif.wd_clear  = 1'b0;
    model_reset();
    do_reset();

    // combinational mask cases
    pif.stall_req = 6'b000100; #1; chk("mask_000100", 64'(pif.stall), 64'(6'b000111));
    pif.stall_req = 6'b001010; #1; chk("mask_001010", 64'(pif.stall), 64'(6'b001111));
    pif.stall_req = 6'b100000; #1; chk("mask_100000", 64'(pif.stall), 64'(6'b111111));
    pif.stall_req = 6'b000000; #1; chk("mask_none",   64'(pif.stall), 64'd0);
    pif.stall_req = '0;

    // single flush: stall suppressed in all three flush cycles
    step('1, 1'b1, 32'h180, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step('1, 1'b0, 32'h0, 1'b0);
      chk("flush_pc180", 64'(pif.new_pc), 64'h180);
    end
    step('0, 1'b0, 32'h0, 1'b0);
    chk("flush_done", 64'(pif.flush), 64'd0);

    // back-to-back: second request in the second flush cycle
    step('0, 1'b1, 32'h100, 1'b0);
    step('0, 1'b0, 32'h0, 1'b0);
    step('1, 1'b1, 32'h200, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_flush", 64'(pif.flush), 64'd1);
      chk("b2b_pc", 64'(pif.new_pc), 64'h200);
      step('1, 1'b0, 32'h0, 1'b0);
    end
    chk("b2b_end", 64'(pif.flush), 64'd0);

    // watchdog: 7 stalls and a gap do not trip
    do_reset();
    for (int i = 0; i < 7; i++) step(6'b000001, 1'b0, 32'h0, 1'b0);
    step('0, 1'b0, 32'h0, 1'b0);
    chk("wd_7", 64'(pif.stall_timeout), 64'd0);
    for (int i = 0; i < 8; i++) step(6'b010000, 1'b0, 32'h0, 1'b0);
    chk("wd_8", 64'(pif.stall_timeout), 64'd1);
    step('0, 1'b0, 32'h0, 1'b0);
    step('0, 1'b0, 32'h0, 1'b0);
    chk("wd_hold", 64'(pif.stall_timeout), 64'd1);
    step('0, 1'b0, 32'h0, 1'b1);
    chk("wd_clear", 64'(pif.stall_timeout), 64'd0);
    for (int i = 0; i < 7; i++) step(6'b000010, 1'b0, 32'h0, 1'b0);
    step(6'b000010, 1'b0, 32'h0, 1'b1);
    chk("wd_clear_vs_trip", 64'(pif.stall_timeout), 64'd1);
    step('0, 1'b0, 32'h0, 1'b1);

    // counter wrap at CNT_W=4
    do_reset();
    for (int i = 0; i < 17; i++) step(6'b000001, 1'b0, 32'h0, 1'b0);
    chk("wrap_17", 64'(pif.stall_cycles), 64'd1);

    // asynchronous reset in the middle of a flush
    step('0, 1'b1, 32'hdead_beef, 1'b0);
    @(negedge clk);
    pif.flush_req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_flush", 64'(pif.flush), 64'd0);
    chk("arst_new_pc", 64'(pif.new_pc), 64'd0);
    chk("arst_cycles", 64'(pif.stall_cycles), 64'd0);
    chk("arst_stall", 64'(pif.stall), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [STAGES-1:0] sr;
      sr = ($urandom_range(0, 9) < 2) ? '0 : STAGES'($urandom_range(1, (1 << STAGES) - 1));
      if ($urandom_range(0, 3) == 0) sr = 6'b000001;
      step(sr, $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
